maestro_memoria: RTL and testbench
==================================

# maestro_memoria

Bus master for the CPUCR main-memory interface. It drives the 16-bit address bus, the bidirectional 8-bit data bus and the read/write strobe (LE). It executes four requests issued through a start/done handshake: single-byte read, single-byte write, block copy and block fill. It sits between the CPU core (or a loader/DMA front end) and the system memory.

## Interface

Parameters: none.

- clk, input, 1: system clock; all state changes on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- inicio, input, 1: start request; sampled only in IDLE.
- modo, input, 2: request type. 00 = read, 01 = write, 10 = copy, 11 = fill.
- dir_fuente, input, 16: read address (read) or source start (copy).
- dir_destino, input, 16: write address (write) or destination start (copy, fill).
- longitud, input, 16: byte count for copy/fill. 0 = no transfer. Ignored for read and write.
- dato_in, input, 8: byte for write/fill.
- dato_out, output, 8: last byte read from memory.
- ocupado, output, 1: high in every state except IDLE.
- listo, output, 1: one-cycle completion pulse.
- Direccion, output, 16: system address bus.
- Datos, inout, 8: system data bus. Driven only while LE = 0, high-Z otherwise.
- LE, output, 1: 1 = read (memory drives Datos), 0 = write (memory stores Datos on the falling edge).

## Operation

- Request operands (modo, addresses, longitud, dato_in) are latched on the edge where inicio is accepted. Later input changes have no effect.
- inicio is ignored while ocupado = 1.
- States:
  - IDLE
  - RA: read address phase, LE = 1.
  - WS: write strobe, LE = 0, data driven.
  - WH: write hold, LE = 0, data driven.
  - WR: write recovery, LE = 1, bus released.
  - DONE: listo = 1.
- Transitions:
  - IDLE --inicio--> RA (read, copy); WS (write; fill with longitud ≠ 0); DONE (copy or fill with longitud = 0).
  - RA: Datos is captured into a byte register at the edge leaving RA. Read → DONE; copy → WS.
  - WS → WH → WR.
  - WR: count = 0 → DONE. Copy → RA. Fill → WS.
  - DONE → IDLE.
- Read: Direccion = dir_fuente during RA; dato_out is updated at the RA exit edge.
- Copy: each byte is read at the source pointer, then written at the destination pointer. dato_out tracks each byte read.
- Write/fill: the byte written is dato_in (write, fill) or the byte captured in RA (copy).
- Pointers and count:
  - Source and destination pointers are 16 bits and increment by 1 at the WR exit edge.
  - Pointers wrap 0xFFFF → 0x0000 silently.
  - The remaining count decrements at the WR exit edge; write mode uses an internal count of 1.
- Direccion selection: source pointer in RA, destination pointer in WS/WH/WR. In IDLE/DONE it holds its last value.
- Datos driver:
  - Enable and LE come from the same state register, so LE falling and Datos becoming driven happen on the same clock edge.
  - The driver is released on the edge LE rises.
  - The master never drives Datos while LE = 1.
- Reset (asynchronous, any state):
  - State → IDLE. LE = 1, Datos = Z, Direccion = 0x0000, dato_out = 0x00, ocupado = 0, listo = 0.
  - A transfer in progress is abandoned. A byte whose LE falling edge already occurred stays written.

## Timing

- Cycle counts start at the edge accepting inicio (edge 0).
- Read: RA in cycle 1; dato_out valid and listo = 1 in cycle 2; ocupado = 0 from cycle 3.
- Write: WS in cycle 1, WH in cycle 2, WR in cycle 3, listo in cycle 4.
- Fill, N ≥ 1: 3 cycles per byte; listo in cycle 3N+1.
- Copy, N ≥ 1: 4 cycles per byte; listo in cycle 4N+1.
- Length 0 (copy/fill): listo in cycle 1, with no LE activity.
- LE low for exactly 2 cycles per byte (WS, WH), followed by at least 1 cycle high (WR) before the next strobe.
- Back-to-back: inicio high in the DONE cycle is ignored. It is accepted on the next edge (IDLE), so new work starts at least 2 cycles after listo.

## Test plan

- Read: memory[0x0102] = 0xA5. Pulse inicio, modo = 00, dir_fuente = 0x0102 → Direccion = 0x0102 with LE = 1 in cycle 1; dato_out = 0xA5 and listo in cycle 2; Datos never driven by master.
- Write: modo = 01, dir_destino = 0x1000, dato_in = 0x3C → LE low in cycles 1–2 with Datos = 0x3C; memory[0x1000] = 0x3C; listo in cycle 4.
- Copy: memory[0x0000..0x0003] = 11, 22, 33, 44. modo = 10, src = 0x0000, dst = 0x2000, longitud = 4 → memory[0x2000..0x2003] = 11, 22, 33, 44; listo in cycle 17; dato_out = 0x44.
- Fill with wrap: modo = 11, dst = 0xFFFE, longitud = 3, dato_in = 0xEE → 0xFFFE, 0xFFFF and 0x0000 all = 0xEE; listo in cycle 10.
- Zero length and ignored inicio: copy with longitud = 0 → listo in cycle 1, LE constant 1. Pulsing inicio mid-fill does not alter the transfer or its completion cycle.
- Reset mid-copy: assert rst_n = 0 during WH of byte 2 → outputs immediately LE = 1, Datos = Z, Direccion = 0, ocupado = 0. Bytes 1–2 are written, bytes 3+ untouched. A new read after release works normally.

Source files
------------

// File: rtl/maestro_memoria_if.sv
// maestro_memoria_if: request/completion handshake between a requester and the memory master
interface maestro_memoria_if;
    logic        inicio;
    logic [1:0]  modo;
    logic [15:0] dir_fuente;
    logic [15:0] dir_destino;
    logic [15:0] longitud;
    logic [7:0]  dato_in;
    logic [7:0]  dato_out;
    logic        ocupado;
    logic        listo;

    modport master (
        output inicio, modo, dir_fuente, dir_destino, longitud, dato_in,
        input  dato_out, ocupado, listo
    );

    modport slave (
        input  inicio, modo, dir_fuente, dir_destino, longitud, dato_in,
        output dato_out, ocupado, listo
    );
endinterface

// File: rtl/maestro_memoria.sv
// maestro_memoria: CPUCR main-memory bus master executing read, write, block copy and block fill
module maestro_memoria (
    input  logic             clk,
    input  logic             rst_n,
    maestro_memoria_if.slave pet,
    output logic [15:0]      Direccion,
    inout  wire  [7:0]       Datos,
    output logic             LE
);
    localparam logic [1:0] LEER = 2'b00, ESCRIBIR = 2'b01, COPIAR = 2'b10;

    typedef enum logic [2:0] {IDLE, RA, WS, WH, WR, DONE} estado_t;
    estado_t estado, siguiente;

    logic [1:0]  modo_q;
    logic [15:0] fuente, destino, cuenta, fuente_n, destino_n;
    logic [7:0]  dato_q, dato_rd;
    logic        acepta;

    assign acepta    = estado == IDLE && pet.inicio;
    assign fuente_n  = acepta ? pet.dir_fuente  : estado == WR ? fuente + 16'd1  : fuente;
    assign destino_n = acepta ? pet.dir_destino : estado == WR ? destino + 16'd1 : destino;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= IDLE;
        else        estado <= siguiente;
    end

    always_comb begin
        siguiente = estado;
        case (estado)
            IDLE: if (pet.inicio)
                      siguiente = pet.modo == LEER     ? RA :
                                  pet.modo == ESCRIBIR ? WS :
                                  pet.longitud == 16'd0 ? DONE :
                                  pet.modo == COPIAR   ? RA : WS;
            RA:   siguiente = modo_q == LEER ? DONE : WS;
            WS:   siguiente = WH;
            WH:   siguiente = WR;
            WR:   siguiente = cuenta == 16'd1 ? DONE : modo_q == COPIAR ? RA : WS;
            default: siguiente = IDLE;
        endcase
    end

    always_comb begin
        LE          = !(estado == WS || estado == WH);
        pet.ocupado = estado != IDLE;
        pet.listo   = estado == DONE;
    end

    // Direccion is registered so it holds its last value through DONE/IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fuente    <= '0;
            destino   <= '0;
            cuenta    <= '0;
            modo_q    <= LEER;
            dato_q    <= '0;
            dato_rd   <= '0;
            Direccion <= '0;
        end else begin
            fuente  <= fuente_n;
            destino <= destino_n;
            if (acepta) begin
                modo_q <= pet.modo;
                cuenta <= pet.modo == ESCRIBIR ? 16'd1 : pet.longitud;
                dato_q <= pet.dato_in;
            end else if (estado == WR) begin
                cuenta <= cuenta - 16'd1;
            end
            if (estado == RA) dato_rd <= Datos;
            if (siguiente == RA) Direccion <= fuente_n;
            else if (siguiente == WS || siguiente == WH || siguiente == WR) Direccion <= destino_n;
        end
    end

    assign pet.dato_out = dato_rd;
    assign Datos = LE ? 8'hzz : (modo_q == COPIAR ? dato_rd : dato_q);
endmodule

// File: tb/tb_maestro_memoria.sv
// tb_maestro_memoria: randomized and directed checks of maestro_memoria against a byte-array reference
module tb_maestro_memoria;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    wire  [15:0] dir;
    wire  [7:0]  datos;
    wire         le;

    maestro_memoria_if pet();

    maestro_memoria dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pet       (pet),
        .Direccion (dir),
        .Datos     (datos),
        .LE        (le)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        ld = 1'b0;
    logic [15:0] ld_a = '0;
    logic [7:0]  ld_d = '0;
    logic [7:0]  exp_do = '0;
    int          n_chk = 0, n_err = 0;

    assign datos = le ? mem[dir] : 8'hzz;

    always @(posedge clk) begin
        if (ld) mem[ld_a] <= ld_d;
        else if (!le) mem[dir] <= datos;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        ld_a = a;
        ld_d = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] m, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] l, input logic [7:0] v);
        int n, ecyc, cyc, lows;
        logic [7:0] b;
        n    = m == 2'b00 ? 0 : m == 2'b01 ? 1 : int'(l);
        ecyc = m == 2'b00 ? 2 : m == 2'b01 ? 4 : l == 0 ? 1 : m == 2'b10 ? 4 * n + 1 : 3 * n + 1;
        if (m == 2'b00) exp_do = ref_mem[s];
        for (int i = 0; i < n; i++) begin
            b = m == 2'b10 ? ref_mem[16'(s + 16'(i))] : v;
            ref_mem[16'(d + 16'(i))] = b;
            if (m == 2'b10) exp_do = b;
        end
        @(negedge clk);
        pet.inicio = 1'b1;
        pet.modo = m;
        pet.dir_fuente = s;
        pet.dir_destino = d;
        pet.longitud = l;
        pet.dato_in = v;
        @(posedge clk);
        #1;
        cyc = 1;
        lows = 0;
        if (m == 2'b00 || (m == 2'b10 && n > 0)) check("dir_c1_src", dir, s);
        else if (n > 0) check("dir_c1_dst", dir, d);
        while (!pet.listo && cyc < 300) begin
            if (!le) lows++;
            pet.inicio = 1'($urandom);
            pet.modo = 2'($urandom);
            pet.dir_fuente = 16'($urandom);
            pet.dir_destino = 16'($urandom);
            pet.longitud = 16'($urandom);
            pet.dato_in = 8'($urandom);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("listo_cycle", cyc, ecyc);
        check("le_low_cycles", lows, 2 * n);
        check("dato_out", pet.dato_out, exp_do);
        check("ocupado_done", pet.ocupado, 1);
        pet.inicio = 1'b1;
        @(posedge clk);
        #1;
        pet.inicio = 1'b0;
        check("ocupado_idle", pet.ocupado, 0);
        for (int i = 0; i < n; i++)
            check("mem_dst", mem[16'(d + 16'(i))], ref_mem[16'(d + 16'(i))]);
    endtask

    initial begin
        pet.inicio = 1'b0;
        pet.modo = 2'b00;
        pet.dir_fuente = '0;
        pet.dir_destino = '0;
        pet.longitud = '0;
        pet.dato_in = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        #2;
        check("rst_le", le, 1);
        check("rst_dir", dir, 0);
        check("rst_dato_out", pet.dato_out, 0);
        check("rst_ocupado", pet.ocupado, 0);
        check("rst_listo", pet.listo, 0);
        ld = 1'b1;
        load(16'h0102, 8'hA5);
        load(16'h0000, 8'h11);
        load(16'h0001, 8'h22);
        load(16'h0002, 8'h33);
        load(16'h0003, 8'h44);
        for (int i = 0; i < 64; i++) load(16'h4000 + 16'(i), 8'($urandom));
        ld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run(2'b00, 16'h0102, 16'h0000, 16'd0, 8'h00);
        run(2'b01, 16'h0000, 16'h1000, 16'd0, 8'h3C);
        run(2'b10, 16'h0000, 16'h2000, 16'd4, 8'h00);
        run(2'b11, 16'h0000, 16'hFFFE, 16'd3, 8'hEE);
        check("wrap_0000", mem[16'h0000], 8'hEE);
        run(2'b10, 16'h4000, 16'h5000, 16'd0, 8'h00);

        // abandon a copy during WH of its second byte
        ref_mem[16'h3000] = ref_mem[16'h4010];
        ref_mem[16'h3001] = ref_mem[16'h4011];
        @(negedge clk);
        pet.inicio = 1'b1;
        pet.modo = 2'b10;
        pet.dir_fuente = 16'h4010;
        pet.dir_destino = 16'h3000;
        pet.longitud = 16'd4;
        @(posedge clk);
        #1;
        pet.inicio = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("wh_le_low", le, 0);
        rst_n = 1'b0;
        #1;
        exp_do = 8'h00;
        check("arst_le", le, 1);
        check("arst_dir", dir, 0);
        check("arst_ocupado", pet.ocupado, 0);
        check("arst_dato_out", pet.dato_out, 0);
        for (int i = 0; i < 4; i++)
            check("arst_mem", mem[16'h3000 + 16'(i)], ref_mem[16'h3000 + 16'(i)]);
        @(negedge clk);
        rst_n = 1'b1;
        run(2'b00, 16'h0102, 16'h0000, 16'd0, 8'h00);

        for (int k = 0; k < 40; k++)
            run(2'($urandom), 16'h4000 + 16'($urandom_range(0, 63)), 16'($urandom),
                16'($urandom_range(0, 12)), 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
